// File: rtl/bld_pkg.sv
// Shared definitions for the ABO phenotype decoder and the transfusion matcher:
// phenotype codes, matcher FSM encoding and the red-cell compatibility rule.
package bld_pkg;

  localparam logic [2:0] PH_A   = 3'd0;
  localparam logic [2:0] PH_B   = 3'd1;
  localparam logic [2:0] PH_AB  = 3'd2;
  localparam logic [2:0] PH_O   = 3'd3;
  localparam logic [2:0] PH_ILL = 3'd7;

  typedef enum logic [1:0] {
    S_RCP = 2'd0,  // await recipient code
    S_DNR = 2'd1,  // await donor code
    S_RES = 2'd2   // hold verdict until taken
  } state_t;

  // Codes 4..7 carry no phenotype; only 0..3 are meaningful.
  function automatic logic ph_legal(input logic [2:0] code);
    return (code[2] == 1'b0);
  endfunction

  // Donor cells are acceptable when every antigen they carry is also carried
  // by the recipient (O carries none, AB carries both).
  function automatic logic ph_compat(input logic [2:0] rcp, input logic [2:0] dnr);
    logic r_a, r_b, d_a, d_b;
    r_a = (rcp == PH_A) || (rcp == PH_AB);
    r_b = (rcp == PH_B) || (rcp == PH_AB);
    d_a = (dnr == PH_A) || (dnr == PH_AB);
    d_b = (dnr == PH_B) || (dnr == PH_AB);
    if (dnr == PH_O) return 1'b1;
    return (!d_a || r_a) && (!d_b || r_b);
  endfunction

endpackage

// File: rtl/bld_sat_cnt.sv
// Saturating tally counter with synchronous clear; sticks at all-ones.
module bld_sat_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // Clear has priority over increment; increment stops at the maximum value.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/bld_match.sv
// Recipient/donor transfusion matcher. Takes a recipient code then a donor
// code, holds the verdict until consumed, and tallies consumed verdicts.
module bld_match
  import bld_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       pheno_in,
  input  logic             pheno_vld,
  output logic             pheno_rdy,
  output logic             res_vld,
  input  logic             res_rdy,
  output logic             compat,
  output logic             err,
  output logic [2:0]       rcp_code,
  output logic [2:0]       dnr_code,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] reject_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  state_t state, state_nxt;
  logic   take_code;
  logic   take_res;

  // Handshake qualifiers; both ready/valid outputs depend on state only, so
  // res_rdy never reaches pheno_rdy combinationally.
  assign pheno_rdy = (state != S_RES);
  assign res_vld   = (state == S_RES);
  assign take_code = pheno_vld && pheno_rdy;
  assign take_res  = res_vld && res_rdy;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
    if (rst) state <= S_RCP;
    else     state <= state_nxt;
  end

  // Next-state logic: illegal recipients skip the donor and go straight to a verdict.
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    unique case (state)
      S_RCP: if (take_code) state_nxt = ph_legal(pheno_in) ? S_DNR : S_RES;
      S_DNR: if (take_code) state_nxt = S_RES;
      S_RES: if (take_res)  state_nxt = S_RCP;
      default:              state_nxt = S_RCP;
    endcase
  end

  // Capture codes and form the verdict; all held untouched while in S_RES.
  always_ff @(posedge clk) begin
    if (rst) begin
      rcp_code <= '0;
      dnr_code <= '0;
      compat   <= 1'b0;
      err      <= 1'b0;
    end else if (take_code) begin
      if (state == S_RCP) begin
        rcp_code <= pheno_in;
        if (!ph_legal(pheno_in)) begin
          dnr_code <= '0;
          err      <= 1'b1;
          compat   <= 1'b0;
        end
      end else begin
        dnr_code <= pheno_in;
        err      <= !ph_legal(pheno_in);
        compat   <= ph_legal(pheno_in) && ph_compat(rcp_code, pheno_in);
      end
    end
  end

  bld_sat_cnt #(.CNT_W(CNT_W)) u_match_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr_cnt),
    .inc (take_res && !err && compat),
    .cnt (match_cnt)
  );

  bld_sat_cnt #(.CNT_W(CNT_W)) u_reject_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr_cnt),
    .inc (take_res && !err && !compat),
    .cnt (reject_cnt)
  );

  bld_sat_cnt #(.CNT_W(CNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr_cnt),
    .inc (take_res && err),
    .cnt (err_cnt)
  );

endmodule

// File: tb/tb_bld_match.sv
// Self-checking bench for bld_match, with narrow tallies so saturation is reachable.
module tb_bld_match;

  localparam int CNT_W = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       pheno_in;
  logic             pheno_vld;
  logic             pheno_rdy;
  logic             res_vld;
  logic             res_rdy;
  logic             compat;
  logic             err;
  logic [2:0]       rcp_code;
  logic [2:0]       dnr_code;
  logic             clr_cnt;
  logic [CNT_W-1:0] match_cnt;
  logic [CNT_W-1:0] reject_cnt;
  logic [CNT_W-1:0] err_cnt;

  int checks   = 0;
  int failures = 0;
  int m_match  = 0;
  int m_rej    = 0;
  int m_err    = 0;

  always #5 clk = ~clk;

  bld_match #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .pheno_in   (pheno_in),
    .pheno_vld  (pheno_vld),
    .pheno_rdy  (pheno_rdy),
    .res_vld    (res_vld),
    .res_rdy    (res_rdy),
    .compat     (compat),
    .err        (err),
    .rcp_code   (rcp_code),
    .dnr_code   (dnr_code),
    .clr_cnt    (clr_cnt),
    .match_cnt  (match_cnt),
    .reject_cnt (reject_cnt),
    .err_cnt    (err_cnt)
  );

  // Reference rule: O gives to all, AB receives from all, same type always works.
  function automatic bit ref_compat(input int r, input int d);
    if (r > 3 || d > 3) return 1'b0;
    return (d == 3) || (d == r) || (r == 2);
  endfunction

  function automatic int sat_inc(input int v);
    return (v < MAXC) ? v + 1 : MAXC;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_match = 0;
    m_rej   = 0;
    m_err   = 0;
  endtask

  // Present a code and wait (bounded) until it is accepted.
  task automatic send_code(input logic [2:0] c);
    int n = 0;
    pheno_in  = c;
    pheno_vld = 1'b1;
    while (!pheno_rdy && n < 20) begin
      step();
      n++;
    end
    if (!pheno_rdy) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: pheno_rdy=%0b after %0d cycles, required 1", pheno_rdy, n);
    end
    step();
    pheno_vld = 1'b0;
  endtask

  // Consume the verdict, optionally with a coincident clear, and update the model.
  task automatic take_result(input bit e, input bit c, input bit clr);
    res_rdy = 1'b1;
    clr_cnt = clr;
    step();
    res_rdy = 1'b0;
    clr_cnt = 1'b0;
    if (clr)     model_clear();
    else if (e)  m_err   = sat_inc(m_err);
    else if (c)  m_match = sat_inc(m_match);
    else         m_rej   = sat_inc(m_rej);
  endtask

  task automatic test_reset();
    rst = 1'b1; pheno_vld = 1'b0; pheno_in = 3'd5; res_rdy = 1'b0; clr_cnt = 1'b0;
    step();
    step();
    rst = 1'b0;
    model_clear();
    checks++;
    if ({pheno_rdy, res_vld, compat, err, rcp_code, dnr_code} !== {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0}) begin
      failures++;
      $display("FAIL reset_outputs: rdy=%0b vld=%0b compat=%0b err=%0b rcp=%0d dnr=%0d, required 1 0 0 0 0 0",
               pheno_rdy, res_vld, compat, err, rcp_code, dnr_code);
    end
    checks++;
    if ({match_cnt, reject_cnt, err_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_counts: m=%0d r=%0d e=%0d, required 0 0 0", match_cnt, reject_cnt, err_cnt);
    end
  endtask

  task automatic test_basic();
    // AB recipient, A donor: compatible.
    send_code(3'd2);
    send_code(3'd0);
    checks++;
    if ({pheno_rdy, res_vld, err, compat, rcp_code, dnr_code} !== {1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 3'd0}) begin
      failures++;
      $display("FAIL basic_ab_a: rdy=%0b vld=%0b err=%0b compat=%0b rcp=%0d dnr=%0d, required 0 1 0 1 2 0",
               pheno_rdy, res_vld, err, compat, rcp_code, dnr_code);
    end
    take_result(1'b0, 1'b1, 1'b0);
    checks++;
    if ({pheno_rdy, match_cnt, reject_cnt, err_cnt} !== {1'b1, CNT_W'(1), CNT_W'(0), CNT_W'(0)}) begin
      failures++;
      $display("FAIL basic_match_cnt: rdy=%0b m=%0d r=%0d e=%0d, required 1 1 0 0",
               pheno_rdy, match_cnt, reject_cnt, err_cnt);
    end
    // A recipient, B donor: rejected.
    send_code(3'd0);
    send_code(3'd1);
    checks++;
    if ({res_vld, err, compat, rcp_code, dnr_code} !== {1'b1, 1'b0, 1'b0, 3'd0, 3'd1}) begin
      failures++;
      $display("FAIL basic_a_b: vld=%0b err=%0b compat=%0b rcp=%0d dnr=%0d, required 1 0 0 0 1",
               res_vld, err, compat, rcp_code, dnr_code);
    end
    take_result(1'b0, 1'b0, 1'b0);
    checks++;
    if (reject_cnt !== CNT_W'(1)) begin
      failures++;
      $display("FAIL basic_reject_cnt: got %0d, required 1", reject_cnt);
    end
    // Illegal recipient: verdict immediately, no donor consumed.
    send_code(3'd7);
    checks++;
    if ({pheno_rdy, res_vld, err, compat, rcp_code, dnr_code} !== {1'b0, 1'b1, 1'b1, 1'b0, 3'd7, 3'd0}) begin
      failures++;
      $display("FAIL basic_ill_rcp: rdy=%0b vld=%0b err=%0b compat=%0b rcp=%0d dnr=%0d, required 0 1 1 0 7 0",
               pheno_rdy, res_vld, err, compat, rcp_code, dnr_code);
    end
    take_result(1'b1, 1'b0, 1'b0);
    checks++;
    if ({match_cnt, reject_cnt, err_cnt} !== {CNT_W'(m_match), CNT_W'(m_rej), CNT_W'(m_err)}) begin
      failures++;
      $display("FAIL basic_err_cnt: m=%0d r=%0d e=%0d, required %0d %0d %0d",
               match_cnt, reject_cnt, err_cnt, m_match, m_rej, m_err);
    end
    // Next code is a recipient again.
    send_code(3'd3);
    checks++;
    if ({pheno_rdy, res_vld, rcp_code} !== {1'b1, 1'b0, 3'd3}) begin
      failures++;
      $display("FAIL basic_next_rcp: rdy=%0b vld=%0b rcp=%0d, required 1 0 3", pheno_rdy, res_vld, rcp_code);
    end
    send_code(3'd3);
    take_result(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_hold();
    // B recipient, AB donor: rejected; then stall the consumer with a pending code.
    send_code(3'd1);
    send_code(3'd2);
    pheno_vld = 1'b1;
    pheno_in  = 3'd3;
    res_rdy   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({pheno_rdy, res_vld, err, compat, rcp_code, dnr_code} !== {1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 3'd2} ||
          {match_cnt, reject_cnt, err_cnt} !== {CNT_W'(m_match), CNT_W'(m_rej), CNT_W'(m_err)}) begin
        failures++;
        $display("FAIL hold_stable[%0d]: rdy=%0b vld=%0b err=%0b compat=%0b rcp=%0d dnr=%0d m=%0d r=%0d e=%0d, required 0 1 0 0 1 2 %0d %0d %0d",
                 i, pheno_rdy, res_vld, err, compat, rcp_code, dnr_code, match_cnt, reject_cnt, err_cnt,
                 m_match, m_rej, m_err);
      end
    end
    pheno_vld = 1'b0;
    take_result(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_saturate();
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    model_clear();
    checks++;
    if ({match_cnt, reject_cnt, err_cnt} !== '0) begin
      failures++;
      $display("FAIL sat_clear: m=%0d r=%0d e=%0d, required 0 0 0", match_cnt, reject_cnt, err_cnt);
    end
    for (int i = 0; i < 6; i++) begin
      send_code(3'($urandom_range(0, 3)));
      send_code(3'd3);
      take_result(1'b0, 1'b1, i == 5);
      checks++;
      if (match_cnt !== CNT_W'(m_match) || pheno_rdy !== 1'b1) begin
        failures++;
        $display("FAIL sat_match[%0d]: m=%0d rdy=%0b, required %0d 1", i, match_cnt, pheno_rdy, m_match);
      end
    end
  endtask

  task automatic test_rst_mid();
    send_code(3'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_clear();
    checks++;
    if ({pheno_rdy, res_vld, compat, err, rcp_code, dnr_code, match_cnt, reject_cnt, err_cnt} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, {(3*CNT_W){1'b0}}}) begin
      failures++;
      $display("FAIL rst_mid: rdy=%0b vld=%0b compat=%0b err=%0b rcp=%0d dnr=%0d m=%0d r=%0d e=%0d, required reset values",
               pheno_rdy, res_vld, compat, err, rcp_code, dnr_code, match_cnt, reject_cnt, err_cnt);
    end
    send_code(3'd3);
    send_code(3'd3);
    checks++;
    if ({res_vld, err, compat} !== 3'b101) begin
      failures++;
      $display("FAIL rst_mid_oo: vld=%0b err=%0b compat=%0b, required 1 0 1", res_vld, err, compat);
    end
    take_result(1'b0, 1'b1, 1'b0);
    checks++;
    if (match_cnt !== CNT_W'(1)) begin
      failures++;
      $display("FAIL rst_mid_cnt: m=%0d, required 1", match_cnt);
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 6;
    logic [2:0] codes [2*N];
    int idx = 0, done = 0, cyc = 0;
    bit acc;
    for (int i = 0; i < 2*N; i++) codes[i] = 3'($urandom_range(0, 3));
    res_rdy = 1'b1;
    while (done < N && cyc < 100) begin
      pheno_in  = codes[(idx < 2*N) ? idx : 0];
      pheno_vld = (idx < 2*N);
      if (res_vld) begin
        bit c;
        c = ref_compat(codes[2*done], codes[2*done+1]);
        checks++;
        if ({err, compat, rcp_code, dnr_code} !== {1'b0, c, codes[2*done], codes[2*done+1]}) begin
          failures++;
          $display("FAIL b2b_verdict[%0d]: err=%0b compat=%0b rcp=%0d dnr=%0d, required 0 %0b %0d %0d",
                   done, err, compat, rcp_code, dnr_code, c, codes[2*done], codes[2*done+1]);
        end
        if (c) m_match = sat_inc(m_match);
        else   m_rej   = sat_inc(m_rej);
        done++;
      end
      acc = pheno_rdy && (idx < 2*N);
      step();
      cyc++;
      if (acc) idx++;
    end
    res_rdy   = 1'b0;
    pheno_vld = 1'b0;
    checks++;
    if (done != N || cyc != 3*N) begin
      failures++;
      $display("FAIL b2b_throughput: %0d pairings in %0d cycles, required %0d in %0d", done, cyc, N, 3*N);
    end
    checks++;
    if ({match_cnt, reject_cnt, err_cnt} !== {CNT_W'(m_match), CNT_W'(m_rej), CNT_W'(m_err)}) begin
      failures++;
      $display("FAIL b2b_cnt: m=%0d r=%0d e=%0d, required %0d %0d %0d",
               match_cnt, reject_cnt, err_cnt, m_match, m_rej, m_err);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      logic [2:0] rc, dc, exp_dnr;
      bit e, c;
      rc = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      dc = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      send_code(rc);
      if (rc < 4) send_code(dc);
      e       = (rc > 3) || (dc > 3);
      c       = !e && ref_compat(rc, dc);
      exp_dnr = (rc > 3) ? 3'd0 : dc;
      checks++;
      if ({res_vld, err, compat, rcp_code, dnr_code} !== {1'b1, e, c, rc, exp_dnr}) begin
        failures++;
        $display("FAIL rand_verdict[%0d]: vld=%0b err=%0b compat=%0b rcp=%0d dnr=%0d, required 1 %0b %0b %0d %0d",
                 t, res_vld, err, compat, rcp_code, dnr_code, e, c, rc, exp_dnr);
      end
      // Stall with stray codes and clears; neither may disturb the verdict.
      for (int w = $urandom_range(0, 3); w > 0; w--) begin
        pheno_vld = 1'($urandom_range(0, 1));
        pheno_in  = 3'($urandom_range(0, 7));
        clr_cnt   = ($urandom_range(0, 3) == 0);
        step();
        if (clr_cnt) model_clear();
        clr_cnt   = 1'b0;
        pheno_vld = 1'b0;
      end
      checks++;
      if ({res_vld, err, compat, rcp_code, dnr_code} !== {1'b1, e, c, rc, exp_dnr}) begin
        failures++;
        $display("FAIL rand_stall[%0d]: vld=%0b err=%0b compat=%0b rcp=%0d dnr=%0d, required 1 %0b %0b %0d %0d",
                 t, res_vld, err, compat, rcp_code, dnr_code, e, c, rc, exp_dnr);
      end
      take_result(e, c, $urandom_range(0, 5) == 0);
      checks++;
      if ({match_cnt, reject_cnt, err_cnt} !== {CNT_W'(m_match), CNT_W'(m_rej), CNT_W'(m_err)}) begin
        failures++;
        $display("FAIL rand_cnt[%0d]: m=%0d r=%0d e=%0d, required %0d %0d %0d",
                 t, match_cnt, reject_cnt, err_cnt, m_match, m_rej, m_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_saturate();
    test_rst_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bld_match.md
# bld_match

Downstream consumer of the phenotype codes produced by the ABO phenotype decoder. Accepts a recipient code followed by a donor code over a valid/ready handshake, judges red-cell transfusion compatibility, and holds the verdict until it is taken. Keeps saturating tallies of compatible, rejected and erroneous pairings for the blood-bank status display.

## Interface
Parameters:
- CNT_W, 8, width of each tally counter

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- pheno_in  in  3  phenotype code: 0=A, 1=B, 2=AB, 3=O; 4..7 illegal (7 is the decoder's illegal-allele code)
- pheno_vld  in  1  pheno_in valid
- pheno_rdy  out  1  block can accept a code this cycle
- res_vld  out  1  verdict valid
- res_rdy  in  1  consumer takes verdict
- compat  out  1  donor compatible with recipient
- err  out  1  pairing contained an illegal code
- rcp_code  out  3  registered recipient code of current pairing
- dnr_code  out  3  registered donor code of current pairing (0 if never accepted)
- clr_cnt  in  1  synchronous clear of all tallies
- match_cnt  out  CNT_W  compatible verdicts consumed
- reject_cnt  out  CNT_W  incompatible verdicts consumed
- err_cnt  out  CNT_W  erroneous verdicts consumed

## Operation
- FSM states: S_RCP (await recipient), S_DNR (await donor), S_RES (hold verdict).
- pheno_rdy = 1 in S_RCP and S_DNR, 0 in S_RES. Transfer occurs when pheno_vld & pheno_rdy.
- S_RCP, legal code accepted: rcp_code <= code, -> S_DNR.
- S_RCP, illegal code accepted: rcp_code <= code, dnr_code <= 0, err <= 1, compat <= 0, -> S_RES (no donor consumed).
- S_DNR, code accepted: dnr_code <= code; illegal -> err=1, compat=0; legal -> err=0, compat per rule; -> S_RES.
- Compatibility: O donor -> any recipient; A donor -> A or AB; B donor -> B or AB; AB donor -> AB only.
- S_RES: res_vld=1; verdict, rcp_code, dnr_code held stable; on res_vld & res_rdy -> S_RCP.
- Tallies update on result handshake only: err -> err_cnt+1; else compat -> match_cnt+1; else reject_cnt+1.
- Counters saturate at 2^CNT_W-1; no wrap.
- clr_cnt clears all three counters; if coincident with a result handshake, clear wins (counters = 0) but FSM still leaves S_RES.
- clr_cnt has no effect on FSM or verdict outputs.

## Timing
- Reset values: state S_RCP, pheno_rdy=1, res_vld=0, compat=0, err=0, rcp_code=0, dnr_code=0, all counters 0.
- rst mid-pairing (S_DNR or S_RES) discards the partial pairing; no counter update for it.
- Latency: res_vld asserted the cycle after the donor (or illegal recipient) transfer.
- Throughput: one pairing per 3 cycles minimum (recipient, donor, result handshake); res_rdy held high gives exactly 3.
- Counter outputs reflect the handshake one cycle after it.
- pheno_vld while pheno_rdy=0 is ignored; the producer must hold the code until accepted.
- No combinational path from res_rdy to pheno_rdy; a new recipient is accepted the cycle after the result handshake.

## Structure
- Shared package bld_pkg: phenotype code constants (PH_A, PH_B, PH_AB, PH_O, PH_ILL) and FSM state encoding; shared with the phenotype decoder.
- Sub-module bld_sat_cnt (parameter CNT_W; inputs clk, rst, clr, inc; output cnt): saturating counter, instantiated three times.
- Compatibility rule as a function in bld_pkg.

## Test plan
- Reset, then recipient 2 (AB), donor 0 (A), res_rdy=1 -> res_vld one cycle after donor, compat=1, err=0; next cycle match_cnt=1.
- Recipient 0 (A), donor 1 (B) -> compat=0, err=0; reject_cnt=1 after handshake.
- Recipient 7 -> S_RES immediately, err=1, dnr_code=0, pheno_rdy=0; err_cnt=1 after handshake; next code taken as recipient.
- Hold res_rdy=0 for 5 cycles with pheno_vld=1 -> pheno_rdy=0, verdict and codes stable throughout, no counter change.
- CNT_W=2, five O-donor pairings -> match_cnt saturates at 3; clr_cnt coincident with 6th handshake -> match_cnt=0.
- rst asserted in S_DNR after recipient 3 -> all outputs at reset values; next two codes 3,3 give compat=1, match_cnt=1.
